// File: rtl/audio_feeder_pkg.sv
// Shared definitions for the audio stream feeder: FSM states, audio core
// register map and control-word bit positions.
`default_nettype none

package audio_feeder_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR_SET = 4'd1,
    CLR_REL = 4'd2,
    POLL_RD = 4'd3,
    POLL_WT = 4'd4,
    ACCEPT  = 4'd5,
    WR_L    = 4'd6,
    WR_R    = 4'd7,
    BACKOFF = 4'd8
  } feeder_state_t;

  localparam logic [1:0] ADDR_CONTROL   = 2'd0;
  localparam logic [1:0] ADDR_FIFOSPACE = 2'd1;
  localparam logic [1:0] ADDR_LEFT      = 2'd2;
  localparam logic [1:0] ADDR_RIGHT     = 2'd3;

  localparam int          CW_BIT     = 3;
  localparam logic [31:0] CTRL_CLEAR = 32'(1) << CW_BIT;
  localparam logic [31:0] CTRL_RUN   = 32'h0000_0000;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_stream_feeder.sv
// Streams stereo sample pairs into an audio core write FIFO, pacing the
// writes with the core's fifospace credit and counting empty-FIFO underruns.
`default_nettype none

module audio_stream_feeder
  import audio_feeder_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 128,
  parameter int POLL_GAP   = 16
) (
  input  logic                sys_clk_clk,
  input  logic                sys_reset_reset_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] snk_left,
  input  logic [SAMPLE_W-1:0] snk_right,
  input  logic                snk_valid,
  output logic                snk_ready,
  output logic [1:0]          avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic [31:0]         avm_readdata,
  output logic [15:0]         underrun_count,
  output logic                busy
);

  localparam int               GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);
  localparam logic [7:0]       DEPTH8   = 8'(FIFO_DEPTH);

  feeder_state_t    state;
  logic [7:0]       credit;
  logic             first_poll;
  logic [31:0]      right_ext;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0]  wslc;
  logic [7:0]  wsrc;
  logic [7:0]  new_credit;
  logic [31:0] left_in_ext;
  logic [31:0] right_in_ext;
  logic        unused_readdata;

  assign wslc            = avm_readdata[31:24];
  assign wsrc            = avm_readdata[23:16];
  assign new_credit      = min8(wslc, wsrc);
  assign left_in_ext     = 32'(signed'(snk_left));
  assign right_in_ext    = 32'(signed'(snk_right));
  assign unused_readdata = ^avm_readdata[15:0];

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      state          <= IDLE;
      avm_address    <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'd0;
      snk_ready      <= 1'b0;
      busy           <= 1'b0;
      credit         <= 8'd0;
      underrun_count <= 16'd0;
      first_poll     <= 1'b0;
      right_ext      <= 32'd0;
      gap_cnt        <= '0;
    end else begin
      // Strobes default low so every access lasts exactly one cycle.
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      busy           <= 1'b1;
      case (state)
        IDLE: begin
          if (enable) begin
            state          <= CLR_SET;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= ADDR_CONTROL;
            avm_writedata  <= CTRL_CLEAR;
          end else begin
            busy <= 1'b0;
          end
        end
        CLR_SET: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state          <= CLR_REL;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= ADDR_CONTROL;
            avm_writedata  <= CTRL_RUN;
          end
        end
        CLR_REL: begin
          first_poll <= 1'b1;
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state          <= POLL_RD;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_address    <= ADDR_FIFOSPACE;
          end
        end
        POLL_RD: state <= POLL_WT;
        POLL_WT: begin
          credit     <= new_credit;
          first_poll <= 1'b0;
          // The core FIFO reads as fully empty right after a clear; that is not an underrun.
          if (wslc == DEPTH8 && wsrc == DEPTH8 && !first_poll && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
          if (new_credit != 8'd0) begin
            state     <= ACCEPT;
            snk_ready <= 1'b1;
          end else begin
            state   <= BACKOFF;
            gap_cnt <= GAP_LOAD;
          end
        end
        ACCEPT: begin
          if (snk_valid && snk_ready) begin
            state          <= WR_L;
            snk_ready      <= 1'b0;
            right_ext      <= right_in_ext;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= ADDR_LEFT;
            avm_writedata  <= left_in_ext;
          end else if (!enable) begin
            state     <= IDLE;
            snk_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        WR_L: begin
          state          <= WR_R;
          avm_chipselect <= 1'b1;
          avm_write      <= 1'b1;
          avm_address    <= ADDR_RIGHT;
          avm_writedata  <= right_ext;
        end
        WR_R: begin
          credit <= credit - 8'd1;
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (credit > 8'd1) begin
            state     <= ACCEPT;
            snk_ready <= 1'b1;
          end else begin
            state          <= POLL_RD;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_address    <= ADDR_FIFOSPACE;
          end
        end
        BACKOFF: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == '0) begin
            state          <= POLL_RD;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_address    <= ADDR_FIFOSPACE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_stream_feeder.sv
// Directed bench for audio_stream_feeder: a small audio core slave model logs
// every bus access, and vector tables plus hand sequences check the log.
`default_nettype none

module tb_audio_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] snk_left = 16'd0;
  logic [15:0] snk_right = 16'd0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic [15:0] underrun_count;
  logic        busy;

  audio_stream_feeder #(.SAMPLE_W(16), .FIFO_DEPTH(128), .POLL_GAP(16)) dut (
    .sys_clk_clk      (clk),
    .sys_reset_reset_n(rst_n),
    .enable           (enable),
    .snk_left         (snk_left),
    .snk_right        (snk_right),
    .snk_valid        (snk_valid),
    .snk_ready        (snk_ready),
    .avm_address      (avm_address),
    .avm_chipselect   (avm_chipselect),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .underrun_count   (underrun_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Slave model and bus log
  int          cyc = 0;
  int          n_log = 0;
  int          n_reads = 0;
  int          n_xfer = 0;
  int          xfer_cyc = -1;
  int          ready_cnt = 0;
  int          rd_base = 0;
  int          rsel;
  logic [31:0] resp [4];
  int          log_cyc  [512];
  logic        log_wr   [512];
  logic [1:0]  log_addr [512];
  logic [31:0] log_data [512];

  assign rsel = n_reads - rd_base;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_chipselect && (avm_write || avm_read) && n_log < 512) begin
      log_cyc[n_log]  <= cyc;
      log_wr[n_log]   <= avm_write;
      log_addr[n_log] <= avm_address;
      log_data[n_log] <= avm_write ? avm_writedata : 32'd0;
      n_log           <= n_log + 1;
    end
    if (avm_chipselect && avm_read) begin
      avm_readdata <= (rsel >= 0 && rsel < 4) ? resp[rsel] : 32'd0;
      n_reads      <= n_reads + 1;
    end
    if (snk_valid && snk_ready) begin
      xfer_cyc <= cyc;
      n_xfer   <= n_xfer + 1;
    end
    if (snk_ready) ready_cnt <= ready_cnt + 1;
  end

  int passed = 0;
  int total = 0;
  int log_base = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ent(input int i);
    if (i < 0 || i >= n_log) return '1;
    return {29'd0, log_wr[i], log_addr[i], log_data[i]};
  endfunction

  function automatic logic [63:0] mk(input logic wr, input logic [1:0] a, input logic [31:0] d);
    return {29'd0, wr, a, d};
  endfunction

  function automatic int count_wr(input int from, input logic [1:0] a);
    int n = 0;
    for (int i = from; i < n_log; i++) if (log_wr[i] && log_addr[i] == a) n++;
    return n;
  endfunction

  function automatic int cyc_gap(input int i);
    if (i < 1 || i >= n_log) return -1;
    return log_cyc[i] - log_cyc[i-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [31:0] r0, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] r3);
    rst_n = 1'b0;
    enable = 1'b0;
    snk_valid = 1'b0;
    tick();
    tick();
    resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
    rd_base = n_reads;
    log_base = n_log;
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
  endtask

  typedef struct {
    logic [31:0] space;
    logic [15:0] l;
    logic [15:0] r;
    int          pairs;
    logic [31:0] wl;
    logic [31:0] wr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int b;
    int k;
    int rb;
    vecs[0] = '{32'h0203_0000, 16'h1234, 16'h8001, 2, 32'h0000_1234, 32'hFFFF_8001};
    vecs[1] = '{32'h0501_0000, 16'h7FFF, 16'hFFFF, 1, 32'h0000_7FFF, 32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0000, 16'h1111, 16'h2222, 0, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0304_0000, 16'h8000, 16'h0001, 3, 32'hFFFF_8000, 32'h0000_0001};
    vecs[4] = '{32'h00FF_0000, 16'h4444, 16'h5555, 0, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) resp[i] = 32'd0;

    // Reset state
    tick();
    tick();
    check("reset chipselect", 64'(avm_chipselect), 64'd0);
    check("reset read", 64'(avm_read), 64'd0);
    check("reset write", 64'(avm_write), 64'd0);
    check("reset address", 64'(avm_address), 64'd0);
    check("reset writedata", 64'(avm_writedata), 64'd0);
    check("reset snk_ready", 64'(snk_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset underrun", 64'(underrun_count), 64'd0);

    // Vector table: clear sequence, credit-limited pair writes, re-poll
    for (int v = 0; v < 5; v++) begin
      start_session(vecs[v].space, 32'd0, 32'd0, 32'd0);
      snk_left = vecs[v].l;
      snk_right = vecs[v].r;
      snk_valid = 1'b1;
      repeat (45) tick();
      snk_valid = 1'b0;
      b = log_base;
      check($sformatf("v%0d ctrl clear", v), ent(b), mk(1'b1, 2'd0, 32'h8));
      check($sformatf("v%0d ctrl release", v), ent(b+1), mk(1'b1, 2'd0, 32'h0));
      check($sformatf("v%0d ctrl gap", v), 64'(cyc_gap(b+1)), 64'd1);
      check($sformatf("v%0d first poll", v), ent(b+2), mk(1'b0, 2'd1, 32'h0));
      check($sformatf("v%0d poll gap", v), 64'(cyc_gap(b+2)), 64'd1);
      for (int p = 0; p < vecs[v].pairs; p++) begin
        k = b + 3 + 2*p;
        check($sformatf("v%0d p%0d left", v, p), ent(k), mk(1'b1, 2'd2, vecs[v].wl));
        check($sformatf("v%0d p%0d right", v, p), ent(k+1), mk(1'b1, 2'd3, vecs[v].wr));
        check($sformatf("v%0d p%0d adjacent", v, p), 64'(cyc_gap(k+1)), 64'd1);
      end
      k = b + 3 + 2*vecs[v].pairs;
      check($sformatf("v%0d re-poll", v), ent(k), mk(1'b0, 2'd1, 32'h0));
      check($sformatf("v%0d left count", v), 64'(count_wr(b, 2'd2)), 64'(vecs[v].pairs));
      check($sformatf("v%0d underrun", v), 64'(underrun_count), 64'd0);
      if (vecs[v].pairs > 0)
        check($sformatf("v%0d latency", v), 64'(log_cyc[k-2] - xfer_cyc), 64'd1);
    end

    // Zero credit: backoff between polls, sink never ready
    start_session(32'd0, 32'd0, 32'd0, 32'd0);
    snk_valid = 1'b1;
    rb = ready_cnt;
    repeat (60) tick();
    snk_valid = 1'b0;
    check("backoff poll spacing", 64'(cyc_gap(log_base + 3)), 64'd18);
    check("backoff second poll", ent(log_base + 3), mk(1'b0, 2'd1, 32'h0));
    check("backoff ready never", 64'(ready_cnt - rb), 64'd0);

    // Underrun: exempt on first poll, counted on later polls, saturating
    start_session(32'h8080_0000, 32'd0, 32'd0, 32'd0);
    repeat (10) tick();
    check("underrun first poll exempt", 64'(underrun_count), 64'd0);
    check("full credit ready", 64'(snk_ready), 64'd1);
    start_session(32'd0, 32'h8080_0000, 32'h8080_0000, 32'd0);
    repeat (30) tick();
    check("underrun second poll", 64'(underrun_count), 64'd1);
    force dut.underrun_count = 16'hFFFF;
    tick();
    release dut.underrun_count;
    snk_left = 16'h0101;
    snk_right = 16'h0202;
    snk_valid = 1'b1;
    for (int t = 0; t < 600 && (n_reads - rd_base) < 3; t++) tick();
    snk_valid = 1'b0;
    check("third poll reached", 64'((n_reads - rd_base) >= 3), 64'd1);
    tick();
    tick();
    check("underrun saturates", 64'(underrun_count), 64'hFFFF);

    // Enable dropped in the transfer cycle: pair still completes, then idle
    start_session(32'h0505_0000, 32'd0, 32'd0, 32'd0);
    for (int t = 0; t < 20 && !snk_ready; t++) tick();
    check("drop ready seen", 64'(snk_ready), 64'd1);
    snk_left = 16'h00AA;
    snk_right = 16'hFF55;
    snk_valid = 1'b1;
    enable = 1'b0;
    tick();
    snk_valid = 1'b0;
    repeat (8) tick();
    check("drop left count", 64'(count_wr(log_base, 2'd2)), 64'd1);
    check("drop right count", 64'(count_wr(log_base, 2'd3)), 64'd1);
    check("drop right data", ent(n_log - 1), mk(1'b1, 2'd3, 32'hFFFF_FF55));
    check("drop pair adjacent", 64'(cyc_gap(n_log - 1)), 64'd1);
    check("drop busy", 64'(busy), 64'd0);
    check("drop ready", 64'(snk_ready), 64'd0);

    // Reset during WR_L: strobes drop at once, right write abandoned, re-clear on resume
    start_session(32'h0202_0000, 32'd0, 32'd0, 32'd0);
    snk_left = 16'h0A0A;
    snk_right = 16'h0B0B;
    snk_valid = 1'b1;
    for (int t = 0; t < 20 && !(avm_write && avm_address == 2'd2); t++) tick();
    check("wr_l reached", 64'(avm_write && avm_address == 2'd2), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst chipselect", 64'(avm_chipselect), 64'd0);
    check("rst write", 64'(avm_write), 64'd0);
    check("rst read", 64'(avm_read), 64'd0);
    check("rst address", 64'(avm_address), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("rst no right write", 64'(count_wr(log_base, 2'd3)), 64'd0);
    b = n_log;
    rst_n = 1'b1;
    repeat (6) tick();
    check("resume ctrl clear", ent(b), mk(1'b1, 2'd0, 32'h8));
    check("resume ctrl release", ent(b+1), mk(1'b1, 2'd0, 32'h0));
    snk_valid = 1'b0;
    enable = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/audio_stream_feeder.md
AUDIO_STREAM_FEEDER -- requirements
Module: audio_stream_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, input sample width (8..32), sign-extended to 32 bits on write.
REQ-002 SHALL have parameter FIFO_DEPTH, default 128, audio core write-FIFO depth per channel.
REQ-003 SHALL have parameter POLL_GAP, default 16, idle cycles between polls when credit is 0.
REQ-004 SHALL have port sys_clk_clk  in  1  sole clock.
REQ-005 SHALL have port sys_reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  level; high = stream samples to audio core.
REQ-007 SHALL have ports snk_left / snk_right  in  SAMPLE_W each  stereo sample pair.
REQ-008 SHALL have ports snk_valid in 1 / snk_ready out 1  sample handshake; transfer when both high on a clock edge.
REQ-009 SHALL have ports avm_address out 2, avm_chipselect out 1, avm_read out 1, avm_write out 1, avm_writedata out 32  master side of audio core slave.
REQ-010 SHALL have port avm_readdata  in  32  audio core read data, valid exactly one cycle after a read cycle.
REQ-011 SHALL have port underrun_count  out  16  saturating count of polls reporting empty core FIFO.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL use core register map: 0 control, 1 fifospace, 2 left data, 3 right data; fifospace[31:24]=WSLC, [23:16]=WSRC.
REQ-014 SHALL implement FSM states IDLE, CLR_SET, CLR_REL, POLL_RD, POLL_WT, ACCEPT, WR_L, WR_R, BACKOFF.
REQ-015 SHALL drive all avm_* outputs registered; every bus access lasts exactly one cycle with chipselect high.
REQ-016 SHALL leave IDLE for CLR_SET when enable=1; CLR_SET writes control=0x8 (clear write FIFO), CLR_REL writes control=0x0, then POLL_RD.
REQ-017 SHALL in POLL_RD issue read of address 1; POLL_WT captures avm_readdata and loads credit = min(WSLC, WSRC) (8 bits).
REQ-018 SHALL increment underrun_count (saturating at 0xFFFF) in POLL_WT when WSLC==FIFO_DEPTH and WSRC==FIFO_DEPTH, except on the first poll after CLR_REL.
REQ-019 SHALL go POLL_WT -> ACCEPT if credit>0, else -> BACKOFF, which waits POLL_GAP cycles then -> POLL_RD.
REQ-020 SHALL assert snk_ready only in ACCEPT; on transfer latch both samples and go to WR_L; no transfer -> remain in ACCEPT.
REQ-021 SHALL in WR_L write sign-extended left to address 2, in WR_R write right to address 3 and decrement credit.
REQ-022 SHALL after WR_R go to ACCEPT if decremented credit>0, else POLL_RD.
REQ-023 SHALL sample enable only in ACCEPT, BACKOFF, POLL_RD (before issuing) and CLR_SET; enable=0 there -> IDLE; a latched pair SHALL always complete both WR_L and WR_R.
REQ-024 SHALL never write left without the matching right in the next cycle.
REQ-025 SHALL have pipeline latency: sample transfer edge -> left write 1 cycle -> right write 2 cycles.

Reset
REQ-026 SHALL on reset assertion immediately force IDLE, avm_chipselect/read/write=0, avm_address=0, avm_writedata=0, snk_ready=0, busy=0, credit=0, underrun_count=0.
REQ-027 SHALL on reset mid-operation abandon any pending right-channel write; subsequent enable performs CLR sequence, restoring channel alignment.

Structure
REQ-028 SHALL place state enum, register address constants and control CW bit position (3) in shared package audio_feeder_pkg.
REQ-029 SHALL be a single module; no sub-module is warranted.

Verification
REQ-030 Reset then enable=1 -> control writes 0x8 then 0x0 on consecutive cycles, then read of address 1.
REQ-031 fifospace=0x0203_0000, snk_valid held high with pairs (0x1234,0x8001) -> exactly 2 pairs written: addr2 0x0000_1234, addr3 0xFFFF_8001, then re-poll.
REQ-032 fifospace=0x0000_0000 -> BACKOFF 16 cycles, next read exactly 18 cycles after previous read, snk_ready stays 0.
REQ-033 fifospace=0x8080_0000 on second poll -> underrun_count 0->1; forced 0xFFFF stays 0xFFFF.
REQ-034 enable dropped in cycle of sample transfer -> WR_L and WR_R both complete, then IDLE, busy=0.
REQ-035 reset asserted during WR_L -> all avm strobes low same cycle, no addr3 write follows.
